otter_csr_file: RTL and testbench

OTTER_CSR_FILE -- requirements
Module: otter_csr_file

---
 rtl/otter_csr_file.sv | 261 ++++++++++++++++++++++++++
 tb/tb_otter_csr_file.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_csr_file.sv
// otter_csr_file: machine-mode CSR file for the OTTER core.
// Holds mstatus/misa/mie/mip/mtvec/mscratch/mepc/mcause/mtval/mstatush and
// resolves interrupt priority and the trap target address.
// Optional feature macro: OTTER_CSR_COUNTERS_EN adds mcycle/minstret/mcountinhibit
// and the cycle/instret read-only shadows.
// op_sel encoding: 0 NOP, 1 WRITE, 2 INTRPT, 3 ECALL, 4 EBREAK, 5 TRAP, 6 MRET.
// mcause_sel is the synchronous exception code itself (0..7).
module otter_csr_file #(
  parameter int unsigned NUM_CUSTOM_IRQ      = 4,
  parameter bit          VECTORED_EN_DEFAULT = 1'b1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [2:0]                                     op_sel,
  input  logic [2:0]                                     mcause_sel,
  input  logic [1:0]                                     funct3_low,
  input  logic                                           w_en,
  input  logic [11:0]                                    addr,
  input  logic [31:0]                                    w_data,
  input  logic [31:0]                                    pc_addr,
  input  logic [31:0]                                    mtval_trap_addr,
  input  logic                                           irq_ext,
  input  logic                                           irq_timer,
  input  logic                                           irq_soft,
  input  logic [((NUM_CUSTOM_IRQ > 0) ? NUM_CUSTOM_IRQ : 1)-1:0] irq_custom,
  input  logic                                           instret,
  output logic                                           intrpt_vld,
  output logic [4:0]                                     intrpt_code,
  output logic [31:0]                                    trap_vector,
  output logic [31:0]                                    mepc_out,
  output logic                                           read_only,
  output logic                                           addr_vld,
  output logic [31:0]                                    r_data
);

  typedef enum logic [2:0] {
    CSR_OP_NOP    = 3'd0,
    CSR_OP_WRITE  = 3'd1,
    CSR_OP_INTRPT = 3'd2,
    CSR_OP_ECALL  = 3'd3,
    CSR_OP_EBREAK = 3'd4,
    CSR_OP_TRAP   = 3'd5,
    CSR_OP_MRET   = 3'd6
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSTATUSH = 12'h310;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  localparam logic [31:0] MISA_VAL    = 32'h4000_0100;
  localparam logic [31:0] MEPC_MASK   = 32'hFFFF_FFFC;
  localparam logic [31:0] MCAUSE_MASK = 32'h8000_001F;
  localparam logic [31:0] CUSTOM_MASK = ((32'h1 << NUM_CUSTOM_IRQ) - 32'h1) << 16;
  localparam logic [31:0] IRQ_MASK    = 32'h0000_0888 | CUSTOM_MASK;

  csr_op_e     w_op;
  logic        w_commit;
  logic [31:0] w_wval;
  logic [31:0] w_mtvec_wr;
  logic [31:0] w_mip_next;
  logic [31:0] w_pend;
  logic [31:0] w_exc_cause;
  logic        w_unused_irq;

  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic [31:0] r_mie;
  logic [31:0] r_mip;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;

`ifdef OTTER_CSR_COUNTERS_EN
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;
  logic        r_cy_inh;
  logic        r_ir_inh;
`else
  logic        w_unused_instret;
  assign w_unused_instret = instret;
`endif

  assign w_op         = csr_op_e'(op_sel);
  assign w_unused_irq = ^irq_custom;
  assign w_commit     = (w_op == CSR_OP_WRITE) && w_en && addr_vld && !read_only;
  assign mepc_out     = r_mepc;
  assign w_mtvec_wr   = {w_wval[31:2],
                         (VECTORED_EN_DEFAULT && (w_wval[1:0] == 2'b01)) ? 2'b01 : 2'b00};
  assign w_exc_cause  = (w_op == CSR_OP_ECALL)  ? 32'd11 :
                        (w_op == CSR_OP_EBREAK) ? 32'd3  : {29'b0, mcause_sel};

  // Read mux and address decode
  always_comb begin
    r_data    = '0;
    addr_vld  = 1'b1;
    read_only = 1'b0;
    case (addr)
      CSR_MSTATUS:  r_data = {24'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
      CSR_MISA:     begin r_data = MISA_VAL; read_only = 1'b1; end
      CSR_MSTATUSH: r_data = '0;
      CSR_MIE:      r_data = r_mie;
      CSR_MIP:      r_data = r_mip;
      CSR_MTVEC:    r_data = r_mtvec;
      CSR_MSCRATCH: r_data = r_mscratch;
      CSR_MEPC:     r_data = r_mepc;
      CSR_MCAUSE:   r_data = r_mcause;
      CSR_MTVAL:    r_data = r_mtval;
`ifdef OTTER_CSR_COUNTERS_EN
      CSR_MCOUNTINHIBIT: r_data = {29'b0, r_ir_inh, 1'b0, r_cy_inh};
      CSR_MCYCLE:        r_data = r_mcycle[31:0];
      CSR_MCYCLEH:       r_data = r_mcycle[63:32];
      CSR_MINSTRET:      r_data = r_minstret[31:0];
      CSR_MINSTRETH:     r_data = r_minstret[63:32];
      CSR_CYCLE:         begin r_data = r_mcycle[31:0];    read_only = 1'b1; end
      CSR_CYCLEH:        begin r_data = r_mcycle[63:32];   read_only = 1'b1; end
      CSR_INSTRET:       begin r_data = r_minstret[31:0];  read_only = 1'b1; end
      CSR_INSTRETH:      begin r_data = r_minstret[63:32]; read_only = 1'b1; end
`endif
      default: begin addr_vld = 1'b0; read_only = 1'b1; end
    endcase
  end

  // Read-modify-write operand for CSRRW/CSRRS/CSRRC
  always_comb begin
    case (funct3_low)
      2'b10:   w_wval = r_data | w_data;
      2'b11:   w_wval = r_data & ~w_data;
      default: w_wval = w_data;
    endcase
  end

  // Map IRQ inputs onto their mip bit positions
  always_comb begin
    w_mip_next     = '0;
    w_mip_next[3]  = irq_soft;
    w_mip_next[7]  = irq_timer;
    w_mip_next[11] = irq_ext;
    for (int unsigned i = 0; i < NUM_CUSTOM_IRQ; i++) begin
      w_mip_next[16+i] = irq_custom[i];
    end
  end

  // Priority resolve: later assignments win, so custom (high index first) < 7 < 3 < 11
  always_comb begin
    w_pend      = r_mie & r_mip;
    intrpt_code = '0;
    for (int unsigned i = NUM_CUSTOM_IRQ; i > 0; i--) begin
      if (w_pend[15+i]) intrpt_code = 5'(15 + i);
    end
    if (w_pend[7])  intrpt_code = 5'd7;
    if (w_pend[3])  intrpt_code = 5'd3;
    if (w_pend[11]) intrpt_code = 5'd11;
    intrpt_vld = r_mstatus_mie && (|w_pend);
  end

  // Trap target: vectored offset only for interrupts in MODE 1
  always_comb begin
    trap_vector = {r_mtvec[31:2], 2'b00};
    if ((w_op == CSR_OP_INTRPT) && (r_mtvec[1:0] == 2'b01)) begin
      trap_vector = {r_mtvec[31:2], 2'b00} + {25'b0, intrpt_code, 2'b00};
    end
  end

  // Architectural CSR state: software writes, trap entry and MRET
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mip          <= '0;
      r_mtvec        <= '0;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
    end else begin
      r_mip <= w_mip_next;
      case (w_op)
        CSR_OP_WRITE: begin
          if (w_commit) begin
            case (addr)
              CSR_MSTATUS: begin
                r_mstatus_mie  <= w_wval[3];
                r_mstatus_mpie <= w_wval[7];
              end
              CSR_MIE:      r_mie      <= w_wval & IRQ_MASK;
              CSR_MTVEC:    r_mtvec    <= w_mtvec_wr;
              CSR_MSCRATCH: r_mscratch <= w_wval;
              CSR_MEPC:     r_mepc     <= w_wval & MEPC_MASK;
              CSR_MCAUSE:   r_mcause   <= w_wval & MCAUSE_MASK;
              CSR_MTVAL:    r_mtval    <= w_wval;
              default: ;
            endcase
          end
        end
        CSR_OP_INTRPT: begin
          r_mepc         <= pc_addr & MEPC_MASK;
          r_mcause       <= {1'b1, 26'b0, intrpt_code};
          r_mstatus_mpie <= r_mstatus_mie;
          r_mstatus_mie  <= 1'b0;
        end
        CSR_OP_ECALL, CSR_OP_EBREAK, CSR_OP_TRAP: begin
          r_mepc         <= pc_addr & MEPC_MASK;
          r_mcause       <= w_exc_cause;
          r_mstatus_mpie <= r_mstatus_mie;
          r_mstatus_mie  <= 1'b0;
          if (w_op == CSR_OP_TRAP) r_mtval <= mtval_trap_addr;
        end
        CSR_OP_MRET: begin
          r_mstatus_mie  <= r_mstatus_mpie;
          r_mstatus_mpie <= 1'b1;
          r_mcause       <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef OTTER_CSR_COUNTERS_EN
  // Counters: a write to either half replaces this cycle's increment for the whole counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
      r_cy_inh   <= 1'b0;
      r_ir_inh   <= 1'b0;
    end else begin
      if (w_commit && (addr == CSR_MCOUNTINHIBIT)) begin
        r_cy_inh <= w_wval[0];
        r_ir_inh <= w_wval[2];
      end
      if (w_commit && (addr == CSR_MCYCLE))        r_mcycle[31:0]  <= w_wval;
      else if (w_commit && (addr == CSR_MCYCLEH))  r_mcycle[63:32] <= w_wval;
      else if (!r_cy_inh)                          r_mcycle        <= r_mcycle + 64'd1;
      if (w_commit && (addr == CSR_MINSTRET))       r_minstret[31:0]  <= w_wval;
      else if (w_commit && (addr == CSR_MINSTRETH)) r_minstret[63:32] <= w_wval;
      else if (instret && !r_ir_inh)                r_minstret        <= r_minstret + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_otter_csr_file.sv
// Scoreboard bench for otter_csr_file: expected values are queued when
// stimulus is applied and popped when the settled DUT output is sampled.
`timescale 1ns/1ps
module tb_otter_csr_file;

  localparam logic [2:0] OP_NOP = 3'd0, OP_WRITE = 3'd1, OP_INTRPT = 3'd2,
                         OP_ECALL = 3'd3, OP_EBREAK = 3'd4, OP_TRAP = 3'd5, OP_MRET = 3'd6;
  localparam logic [1:0] F_RW = 2'b01, F_RS = 2'b10, F_RC = 2'b11;

  localparam logic [11:0] A_MSTATUS = 12'h300, A_MISA = 12'h301, A_MIE = 12'h304,
                          A_MTVEC = 12'h305, A_MSCRATCH = 12'h340, A_MEPC = 12'h341,
                          A_MCAUSE = 12'h342, A_MTVAL = 12'h343, A_MIP = 12'h344,
                          A_MCINH = 12'h320, A_MCYCLE = 12'hB00, A_MCYCLEH = 12'hB80,
                          A_MINSTRET = 12'hB02, A_MINSTRETH = 12'hB82,
                          A_CYCLE = 12'hC00, A_CYCLEH = 12'hC80, A_INSTRET = 12'hC02;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op_sel;
  logic [2:0]  mcause_sel;
  logic [1:0]  funct3_low;
  logic        w_en;
  logic [11:0] addr;
  logic [31:0] w_data;
  logic [31:0] pc_addr;
  logic [31:0] mtval_trap_addr;
  logic        irq_ext, irq_timer, irq_soft;
  logic [3:0]  irq_custom;
  logic        instret;
  logic        intrpt_vld;
  logic [4:0]  intrpt_code;
  logic [31:0] trap_vector;
  logic [31:0] mepc_out;
  logic        read_only;
  logic        addr_vld;
  logic [31:0] r_data;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  string       sb_tag[$];
  logic [31:0] sb_exp[$];

  otter_csr_file #(
    .NUM_CUSTOM_IRQ(4),
    .VECTORED_EN_DEFAULT(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .op_sel(op_sel), .mcause_sel(mcause_sel),
    .funct3_low(funct3_low), .w_en(w_en), .addr(addr), .w_data(w_data),
    .pc_addr(pc_addr), .mtval_trap_addr(mtval_trap_addr),
    .irq_ext(irq_ext), .irq_timer(irq_timer), .irq_soft(irq_soft),
    .irq_custom(irq_custom), .instret(instret),
    .intrpt_vld(intrpt_vld), .intrpt_code(intrpt_code), .trap_vector(trap_vector),
    .mepc_out(mepc_out), .read_only(read_only), .addr_vld(addr_vld), .r_data(r_data)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_tag.push_back(tag);
    sb_exp.push_back(exp);
  endtask

  // Lets combinational outputs settle, then pops and compares the oldest entry
  task automatic sb_pop_cmp(input int sel);
    string       tag;
    logic [31:0] exp;
    logic [31:0] obs;
    #1;
    if (sb_exp.size() == 0) begin
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      $fatal(1, "scoreboard underflow");
    end
    tag = sb_tag.pop_front();
    exp = sb_exp.pop_front();
    case (sel)
      0:       obs = r_data;
      1:       obs = 32'(intrpt_vld);
      2:       obs = 32'(intrpt_code);
      3:       obs = trap_vector;
      4:       obs = mepc_out;
      5:       obs = 32'(read_only);
      default: obs = 32'(addr_vld);
    endcase
    check(tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    addr   = a;
    op_sel = OP_NOP;
    w_en   = 1'b0;
    sb_push(tag, exp);
    sb_pop_cmp(0);
  endtask

  task automatic expect_out(input int sel, input logic [31:0] exp, input string tag);
    sb_push(tag, exp);
    sb_pop_cmp(sel);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [1:0] f3);
    addr       = a;
    w_data     = d;
    funct3_low = f3;
    op_sel     = OP_WRITE;
    w_en       = 1'b1;
    step();
    op_sel = OP_NOP;
    w_en   = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] pc);
    op_sel  = op;
    pc_addr = pc;
    step();
    op_sel = OP_NOP;
  endtask

  initial begin
    rst = 1'b0; op_sel = OP_NOP; mcause_sel = '0; funct3_low = F_RW; w_en = 1'b0;
    addr = '0; w_data = '0; pc_addr = '0; mtval_trap_addr = '0;
    irq_ext = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0; irq_custom = '0; instret = 1'b0;
    step(); step();

    rd(A_MSTATUS,  32'h0, "rst_mstatus");
    rd(A_MISA,     32'h4000_0100, "rst_misa");
    rd(A_MIE,      32'h0, "rst_mie");
    rd(A_MTVEC,    32'h0, "rst_mtvec");
    rd(A_MEPC,     32'h0, "rst_mepc");
    rd(A_MCAUSE,   32'h0, "rst_mcause");
    rd(A_MTVAL,    32'h0, "rst_mtval");
    rd(A_MSCRATCH, 32'h0, "rst_mscratch");
    expect_out(1, 32'h0, "rst_intrpt_vld");
    rst = 1'b1;
    step();

    wr(A_MTVEC, 32'h0000_1003, F_RW); rd(A_MTVEC, 32'h0000_1000, "mtvec_mode3");
    wr(A_MTVEC, 32'h0000_1002, F_RW); rd(A_MTVEC, 32'h0000_1000, "mtvec_mode2");
    wr(A_MTVEC, 32'h0000_1001, F_RW); rd(A_MTVEC, 32'h0000_1001, "mtvec_mode1");
    wr(A_MEPC, 32'h1234_5677, F_RW);  rd(A_MEPC, 32'h1234_5674, "mepc_mask");
    wr(A_MCAUSE, 32'hFFFF_FFFF, F_RW); rd(A_MCAUSE, 32'h8000_001F, "mcause_mask");
    wr(A_MSCRATCH, 32'hA5A5_0F0F, F_RW); rd(A_MSCRATCH, 32'hA5A5_0F0F, "csrrw");
    wr(A_MSCRATCH, 32'h0000_F0F0, F_RS); rd(A_MSCRATCH, 32'hA5A5_FFFF, "csrrs");
    wr(A_MSCRATCH, 32'hA5A5_0000, F_RC); rd(A_MSCRATCH, 32'h0000_FFFF, "csrrc");
    wr(A_MIE, 32'hFFFF_FFFF, F_RW); rd(A_MIE, 32'h000F_0888, "mie_mask");
    wr(A_MIP, 32'hFFFF_FFFF, F_RW); rd(A_MIP, 32'h0, "mip_wr_ignored");
    wr(A_MISA, 32'h0, F_RW); rd(A_MISA, 32'h4000_0100, "misa_ro_value");
    expect_out(5, 32'h1, "misa_read_only");
    rd(12'h7C0, 32'h0, "unimpl_rdata");
    expect_out(6, 32'h0, "unimpl_addr_vld");
    expect_out(5, 32'h1, "unimpl_read_only");
    wr(A_MSTATUS, 32'hFFFF_FFFF, F_RW); rd(A_MSTATUS, 32'h0000_0088, "mstatus_mask");
    wr(A_MSTATUS, 32'h0, F_RW);

    // External interrupt through vectored mtvec
    wr(A_MIE, 32'h0000_0800, F_RW);
    wr(A_MSTATUS, 32'h0000_0008, F_RW);
    irq_ext = 1'b1;
    expect_out(1, 32'h0, "irq_latency");
    step();
    expect_out(1, 32'h1, "ext_vld");
    expect_out(2, 32'd11, "ext_code");
    rd(A_MIP, 32'h0000_0800, "mip_sampled");
    op_sel = OP_INTRPT; pc_addr = 32'h200;
    expect_out(3, 32'h0000_102C, "tv_vectored");
    step();
    op_sel = OP_NOP;
    rd(A_MEPC, 32'h200, "intr_mepc");
    expect_out(4, 32'h200, "intr_mepc_out");
    rd(A_MCAUSE, 32'h8000_000B, "intr_mcause");
    rd(A_MSTATUS, 32'h0000_0080, "intr_mstatus");
    expect_out(1, 32'h0, "intr_masked");
    do_op(OP_MRET, 32'h0);
    rd(A_MSTATUS, 32'h0000_0088, "mret_mstatus");
    rd(A_MCAUSE, 32'h0, "mret_mcause");
    expect_out(1, 32'h1, "mret_reenable");
    irq_ext = 1'b0;
    step();

    // Priority: 3 over 7, custom lowest index, 11 over custom
    wr(A_MIE, 32'h0000_0088, F_RW);
    irq_soft = 1'b1; irq_timer = 1'b1;
    step();
    expect_out(1, 32'h1, "st_vld");
    expect_out(2, 32'd3, "soft_over_timer");
    irq_soft = 1'b0;
    step();
    expect_out(2, 32'd7, "timer_only");
    irq_timer = 1'b0;
    irq_custom = 4'b0110;
    wr(A_MIE, 32'h0003_0000, F_RW);
    expect_out(1, 32'h1, "custom_vld");
    expect_out(2, 32'd17, "custom_code");
    irq_ext = 1'b1;
    wr(A_MIE, 32'h0003_0800, F_RW);
    expect_out(2, 32'd11, "ext_over_custom");

    // Synchronous exceptions
    op_sel = OP_ECALL; pc_addr = 32'h300;
    expect_out(3, 32'h0000_1000, "tv_exception");
    step();
    op_sel = OP_NOP;
    irq_ext = 1'b0; irq_custom = '0;
    rd(A_MEPC, 32'h300, "ecall_mepc");
    rd(A_MCAUSE, 32'd11, "ecall_mcause");
    rd(A_MSTATUS, 32'h0000_0080, "ecall_mstatus");
    mcause_sel = 3'd2; mtval_trap_addr = 32'hDEAD_BEEF;
    do_op(OP_TRAP, 32'h404);
    rd(A_MEPC, 32'h404, "trap_mepc");
    rd(A_MCAUSE, 32'd2, "trap_mcause");
    rd(A_MTVAL, 32'hDEAD_BEEF, "trap_mtval");
    rd(A_MSTATUS, 32'h0, "trap_mstatus");
    do_op(OP_EBREAK, 32'h508);
    rd(A_MEPC, 32'h508, "ebreak_mepc");
    rd(A_MCAUSE, 32'd3, "ebreak_mcause");

`ifdef OTTER_CSR_COUNTERS_EN
    wr(A_MCINH, 32'hFFFF_FFFF, F_RW); rd(A_MCINH, 32'h5, "mcinh_mask");
    wr(A_MCYCLEH, 32'h5, F_RW);
    wr(A_MCYCLE, 32'hFFFF_FFFF, F_RW);
    rd(A_MCYCLE, 32'hFFFF_FFFF, "mcycle_lo_wr");
    rd(A_MCYCLEH, 32'h5, "mcycle_hi_hold");
    wr(A_MCINH, 32'h0, F_RW);
    rd(A_MCYCLE, 32'hFFFF_FFFF, "mcycle_inhibited");
    step();
    rd(A_MCYCLE, 32'h0, "mcycle_wrap");
    rd(A_MCYCLEH, 32'h6, "mcycle_carry");
    rd(A_CYCLEH, 32'h6, "cycleh_shadow");
    wr(A_MCINH, 32'h1, F_RW);
    step(); step(); step();
    rd(A_MCYCLE, 32'h1, "mcycle_frozen");
    wr(A_MINSTRET, 32'h10, F_RW);
    instret = 1'b1;
    step(); step();
    instret = 1'b0;
    rd(A_MINSTRET, 32'h12, "minstret_count");
    rd(A_INSTRET, 32'h12, "instret_shadow");
    instret = 1'b1;
    wr(A_MINSTRET, 32'h40, F_RW);
    instret = 1'b0;
    rd(A_MINSTRET, 32'h40, "minstret_wr_override");
    rd(A_MINSTRETH, 32'h0, "minstreth_hold");
    addr = A_CYCLE; w_data = 32'h55; funct3_low = F_RW; op_sel = OP_WRITE; w_en = 1'b1;
    expect_out(5, 32'h1, "cycle_read_only");
    step();
    rd(A_CYCLE, 32'h1, "cycle_no_change");
`else
    rd(A_MCYCLE, 32'h0, "no_mcycle_rdata");
    expect_out(6, 32'h0, "no_mcycle_addr");
    rd(A_MCINH, 32'h0, "no_mcinh_rdata");
    expect_out(6, 32'h0, "no_mcinh_addr");
    addr = A_CYCLE; w_data = 32'h55; funct3_low = F_RW; op_sel = OP_WRITE; w_en = 1'b1;
    expect_out(5, 32'h1, "cycle_read_only");
    step();
    rd(A_CYCLE, 32'h0, "cycle_no_change");
`endif
    rd(A_MSCRATCH, 32'h0000_FFFF, "ro_write_no_side_effect");

    // Reset in the middle of traffic, racing a write
    wr(A_MSCRATCH, 32'h1234_5678, F_RW);
    irq_ext = 1'b1;
    rst = 1'b0;
    addr = A_MSCRATCH; w_data = 32'hFFFF_FFFF; funct3_low = F_RW; op_sel = OP_WRITE; w_en = 1'b1;
    step();
    rd(A_MSCRATCH, 32'h0, "mid_rst_mscratch");
    rd(A_MTVEC,    32'h0, "mid_rst_mtvec");
    rd(A_MEPC,     32'h0, "mid_rst_mepc");
    rd(A_MCAUSE,   32'h0, "mid_rst_mcause");
    rd(A_MTVAL,    32'h0, "mid_rst_mtval");
    rd(A_MIE,      32'h0, "mid_rst_mie");
    rd(A_MIP,      32'h0, "mid_rst_mip");
    rd(A_MSTATUS,  32'h0, "mid_rst_mstatus");
    rd(A_MISA,     32'h4000_0100, "mid_rst_misa");
    expect_out(1, 32'h0, "mid_rst_intrpt_vld");
`ifdef OTTER_CSR_COUNTERS_EN
    rd(A_MCYCLE,   32'h0, "mid_rst_mcycle");
    rd(A_MINSTRET, 32'h0, "mid_rst_minstret");
    rd(A_MCINH,    32'h0, "mid_rst_mcinh");
`endif
    rst = 1'b1;
    irq_ext = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
